rs_issue_scheduler: RTL and testbench

- Issue arbiter between the 32-entry reservation station and the three functional units: ALU0, ALU1 and MEM.
- Each cycle it selects the oldest operand-ready entry per unit, offers it with a valid/ready handshake, and pulses a clear back to the station on acceptance.
- ALU-class entries go to whichever ALU is free, replacing fixed FU alternation at dispatch; MEM-class entries go only to MEM.

---
 rtl/rs_issue_scheduler_pkg.sv | 17 +
 rtl/rs_issue_scheduler_picker.sv | 50 +++++
 rtl/rs_issue_scheduler.sv | 118 +++++++++++
 tb/tb_rs_issue_scheduler.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/rs_issue_scheduler_pkg.sv
// Shared types for the reservation-station issue scheduler.
package rs_issue_scheduler_pkg;

  localparam int NUM_FU = 3;

  typedef enum logic [1:0] {
    FU_ALU0 = 2'd0,
    FU_ALU1 = 2'd1,
    FU_MEM  = 2'd2
  } fu_id_e;

  typedef enum logic {
    SCHED_IDLE  = 1'b0,
    SCHED_OFFER = 1'b1
  } sched_state_e;

endpackage

// File: rtl/rs_issue_scheduler_picker.sv
// Combinational picker: oldest candidate by ROB-relative age when RS_AGE_PRIORITY_EN
// is defined, otherwise the lowest-index candidate.
module oldest_ready_picker #(
  parameter int RS_DEPTH = 32,
  parameter int IDX_W    = 5,
  parameter int ROB_W    = 5
) (
  input  logic [RS_DEPTH-1:0]       cand,
  input  logic [RS_DEPTH*ROB_W-1:0] age,
  input  logic [ROB_W-1:0]          rob_head,
  output logic                      found,
  output logic [IDX_W-1:0]          idx
);

`ifdef RS_AGE_PRIORITY_EN
  logic [ROB_W-1:0] rel;
  logic [ROB_W-1:0] best_rel;

  // Subtracting rob_head makes wrapped tags compare correctly; strict < keeps ties on the lower index.
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    rel      = '0;
    best_rel = '1;
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      rel = age[i*ROB_W +: ROB_W] - rob_head;
      if (cand[i] && (!found || rel < best_rel)) begin
        found    = 1'b1;
        idx      = IDX_W'(i);
        best_rel = rel;
      end
    end
  end
`else
  logic unused_age;
  assign unused_age = ^{age, rob_head};

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      if (cand[i] && !found) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/rs_issue_scheduler.sv
// Issue arbiter from the reservation station to ALU0, ALU1 and MEM.
// Selection policy is set by RS_AGE_PRIORITY_EN (oldest-first) or fixed lowest-index.
module rs_issue_scheduler
  import rs_issue_scheduler_pkg::*;
#(
  parameter int RS_DEPTH = 32,
  parameter int IDX_W    = 5,
  parameter int ROB_W    = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [RS_DEPTH-1:0]       entry_valid,
  input  logic [RS_DEPTH-1:0]       entry_ready,
  input  logic [RS_DEPTH-1:0]       entry_is_mem,
  input  logic [RS_DEPTH*ROB_W-1:0] entry_age,
  input  logic [ROB_W-1:0]          rob_head,
  input  logic                      flush,
  input  logic [2:0]                fu_ready,
  output logic [2:0]                issue_valid,
  output logic [3*IDX_W-1:0]        issue_idx,
  output logic [RS_DEPTH-1:0]       issue_clear
);

  sched_state_e        state_q [NUM_FU];
  sched_state_e        state_d [NUM_FU];
  logic [IDX_W-1:0]    idx_q   [NUM_FU];
  logic [IDX_W-1:0]    idx_d   [NUM_FU];
  logic [IDX_W-1:0]    pick_idx[NUM_FU];
  logic [NUM_FU-1:0]   pick_found;
  logic [NUM_FU-1:0]   can_pick;
  logic [RS_DEPTH-1:0] clear_q, clear_d;
  logic [RS_DEPTH-1:0] offered_mask, cand, mem_cand, alu_cand, alu1_cand, alu0_pick_mask;

  // A unit in OFFER only picks when its current offer is accepted this cycle.
  always_comb begin
    offered_mask = '0;
    for (int unsigned u = 0; u < NUM_FU; u++) begin
      can_pick[u] = (state_q[u] == SCHED_IDLE) || fu_ready[u];
      if (state_q[u] == SCHED_OFFER) offered_mask[idx_q[u]] = 1'b1;
    end
  end

  assign cand     = entry_valid & entry_ready & ~offered_mask & ~clear_q;
  assign mem_cand = cand & entry_is_mem;
  assign alu_cand = cand & ~entry_is_mem;

  always_comb begin
    alu0_pick_mask = '0;
    if (can_pick[FU_ALU0] && pick_found[FU_ALU0]) alu0_pick_mask[pick_idx[FU_ALU0]] = 1'b1;
  end

  assign alu1_cand = alu_cand & ~alu0_pick_mask;

  oldest_ready_picker #(.RS_DEPTH(RS_DEPTH), .IDX_W(IDX_W), .ROB_W(ROB_W)) u_pick_mem (
    .cand(mem_cand), .age(entry_age), .rob_head(rob_head),
    .found(pick_found[FU_MEM]), .idx(pick_idx[FU_MEM])
  );

  oldest_ready_picker #(.RS_DEPTH(RS_DEPTH), .IDX_W(IDX_W), .ROB_W(ROB_W)) u_pick_alu0 (
    .cand(alu_cand), .age(entry_age), .rob_head(rob_head),
    .found(pick_found[FU_ALU0]), .idx(pick_idx[FU_ALU0])
  );

  oldest_ready_picker #(.RS_DEPTH(RS_DEPTH), .IDX_W(IDX_W), .ROB_W(ROB_W)) u_pick_alu1 (
    .cand(alu1_cand), .age(entry_age), .rob_head(rob_head),
    .found(pick_found[FU_ALU1]), .idx(pick_idx[FU_ALU1])
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned u = 0; u < NUM_FU; u++) begin
        state_q[u] <= SCHED_IDLE;
        idx_q[u]   <= '0;
      end
      clear_q <= '0;
    end else begin
      for (int unsigned u = 0; u < NUM_FU; u++) begin
        state_q[u] <= state_d[u];
        idx_q[u]   <= idx_d[u];
      end
      clear_q <= clear_d;
    end
  end

  // Flush wins over acceptance, so a squashed offer never produces a clear pulse.
  always_comb begin
    clear_d = '0;
    for (int unsigned u = 0; u < NUM_FU; u++) begin
      state_d[u] = state_q[u];
      idx_d[u]   = idx_q[u];
      if (flush) begin
        state_d[u] = SCHED_IDLE;
        idx_d[u]   = '0;
      end else if (state_q[u] == SCHED_OFFER && fu_ready[u]) begin
        clear_d[idx_q[u]] = 1'b1;
        if (pick_found[u]) idx_d[u] = pick_idx[u];
        else               state_d[u] = SCHED_IDLE;
      end else if (state_q[u] == SCHED_OFFER) begin
        if (!entry_valid[idx_q[u]]) state_d[u] = SCHED_IDLE;
      end else if (pick_found[u]) begin
        state_d[u] = SCHED_OFFER;
        idx_d[u]   = pick_idx[u];
      end
    end
  end

  always_comb begin
    issue_valid = '0;
    issue_idx   = '0;
    for (int unsigned u = 0; u < NUM_FU; u++) begin
      issue_valid[u]               = (state_q[u] == SCHED_OFFER);
      issue_idx[u*IDX_W +: IDX_W] = idx_q[u];
    end
  end

  assign issue_clear = clear_q;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Scoreboard bench for rs_issue_scheduler: directed stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_rs_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] entry_valid = '0;
  logic [31:0] entry_ready = '0;
  logic [31:0] entry_is_mem = '0;
  logic [159:0] entry_age = '0;
  logic [4:0]  rob_head = '0;
  logic        flush = 1'b0;
  logic [2:0]  fu_ready = '0;
  logic [2:0]  issue_valid;
  logic [14:0] issue_idx;
  logic [31:0] issue_clear;

  rs_issue_scheduler #(.RS_DEPTH(32), .IDX_W(5), .ROB_W(5)) dut (
    .clk(clk), .rst(rst), .entry_valid(entry_valid), .entry_ready(entry_ready),
    .entry_is_mem(entry_is_mem), .entry_age(entry_age), .rob_head(rob_head),
    .flush(flush), .fu_ready(fu_ready), .issue_valid(issue_valid),
    .issue_idx(issue_idx), .issue_clear(issue_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  v;
    logic [14:0] idx;
    logic [31:0] clr;
    logic        full;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [14:0] idx_mask;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc == cyc) begin
      mon_e = q.pop_front();
      idx_mask = mon_e.full ? '1 : {{5{mon_e.v[2]}}, {5{mon_e.v[1]}}, {5{mon_e.v[0]}}};
      checks += 3;
      if (issue_valid !== mon_e.v) begin
        errors++;
        $display("FAIL valid cyc %0d got %b exp %b", cyc, issue_valid, mon_e.v);
      end
      if ((issue_idx & idx_mask) !== (mon_e.idx & idx_mask)) begin
        errors++;
        $display("FAIL idx cyc %0d got %h exp %h (mask %h)", cyc, issue_idx, mon_e.idx, idx_mask);
      end
      if (issue_clear !== mon_e.clr) begin
        errors++;
        $display("FAIL clear cyc %0d got %h exp %h", cyc, issue_clear, mon_e.clr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic step(input logic [2:0] v, input int i0, input int i1, input int i2,
                      input logic [31:0] clr, input logic full);
    exp_t e;
    e.cyc  = cyc + 1;
    e.v    = v;
    e.idx  = {5'(i2), 5'(i1), 5'(i0)};
    e.clr  = clr;
    e.full = full;
    q.push_back(e);
    tick();
  endtask

  task automatic set_entry(input int e, input logic v, input logic mem, input int age);
    entry_valid[e]        = v;
    entry_ready[e]        = v;
    entry_is_mem[e]       = mem;
    entry_age[e*5 +: 5]   = 5'(age);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog cyc %0d pending %0d", cyc, q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick();
    step(3'b000, 0, 0, 0, 32'h0, 1'b1);

    // Two ALU entries, both units free
    rst = 1'b0;
    set_entry(3, 1'b1, 1'b0, 4);
    set_entry(7, 1'b1, 1'b0, 2);
    fu_ready = 3'b111;
`ifdef RS_AGE_PRIORITY_EN
    step(3'b011, 7, 3, 0, 32'h0, 1'b0);
`else
    step(3'b011, 3, 7, 0, 32'h0, 1'b0);
`endif
    step(3'b000, 0, 0, 0, 32'h0000_0088, 1'b0);
    step(3'b000, 0, 0, 0, 32'h0, 1'b0);

    // MEM entry held while the unit stalls
    set_entry(3, 1'b0, 1'b0, 0);
    set_entry(7, 1'b0, 1'b0, 0);
    set_entry(5, 1'b1, 1'b1, 9);
    fu_ready = 3'b011;
    for (int k = 0; k < 5; k++) step(3'b100, 0, 0, 5, 32'h0, 1'b0);
    fu_ready = 3'b111;
    step(3'b000, 0, 0, 0, 32'h0000_0020, 1'b0);
    step(3'b000, 0, 0, 0, 32'h0, 1'b0);

    // ROB tag wrap-around, only ALU0 accepting
    set_entry(5, 1'b0, 1'b0, 0);
    rob_head = 5'd30;
    set_entry(0, 1'b1, 1'b0, 31);
    set_entry(1, 1'b1, 1'b0, 1);
    fu_ready = 3'b001;
    step(3'b011, 0, 1, 0, 32'h0, 1'b0);
    step(3'b010, 0, 1, 0, 32'h0000_0001, 1'b0);
    step(3'b010, 0, 1, 0, 32'h0, 1'b0);
    set_entry(0, 1'b0, 1'b0, 0);
    fu_ready = 3'b010;
    step(3'b000, 0, 0, 0, 32'h0000_0002, 1'b0);
    step(3'b000, 0, 0, 0, 32'h0, 1'b0);

    // Withdraw when the offered entry disappears
    set_entry(1, 1'b0, 1'b0, 0);
    set_entry(9, 1'b1, 1'b0, 3);
    fu_ready = 3'b000;
    step(3'b001, 9, 0, 0, 32'h0, 1'b0);
    step(3'b001, 9, 0, 0, 32'h0, 1'b0);
    entry_valid[9] = 1'b0;
    step(3'b000, 0, 0, 0, 32'h0, 1'b0);
    step(3'b000, 0, 0, 0, 32'h0, 1'b0);

    // Flush overrides acceptance on all three units
    set_entry(9, 1'b0, 1'b0, 0);
    set_entry(10, 1'b1, 1'b0, 31);
    set_entry(11, 1'b1, 1'b0, 0);
    set_entry(12, 1'b1, 1'b1, 5);
    step(3'b111, 10, 11, 12, 32'h0, 1'b0);
    step(3'b111, 10, 11, 12, 32'h0, 1'b0);
    flush = 1'b1;
    fu_ready = 3'b111;
    step(3'b000, 0, 0, 0, 32'h0, 1'b1);
    flush = 1'b0;
    fu_ready = 3'b000;
    step(3'b111, 10, 11, 12, 32'h0, 1'b0);

    // Reset mid-offer, then re-offer after release
    rst = 1'b1;
    step(3'b000, 0, 0, 0, 32'h0, 1'b1);
    rst = 1'b0;
    step(3'b111, 10, 11, 12, 32'h0, 1'b0);

    // Back-to-back issue on ALU0
    set_entry(13, 1'b1, 1'b0, 1);
    fu_ready = 3'b001;
    step(3'b111, 13, 11, 12, 32'h0000_0400, 1'b0);
    fu_ready = 3'b000;
    step(3'b111, 13, 11, 12, 32'h0, 1'b0);
    set_entry(10, 1'b0, 1'b0, 0);
    flush = 1'b1;
    step(3'b000, 0, 0, 0, 32'h0, 1'b1);
    flush = 1'b0;
    entry_valid = '0;
    entry_ready = '0;
    step(3'b000, 0, 0, 0, 32'h0, 1'b0);

    tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
